// File: rtl/dcf77_pkg.sv
// dcf77_pkg: DCF77 frame bit positions, FSM states and the loadable time bundle
package dcf77_pkg;
  localparam int DCF_LEN       = 59;
  localparam int DCF_FLAGS_LSB = 15;
  localparam int DCF_START     = 20;
  localparam int DCF_MIN_LSB   = 21;
  localparam int DCF_P1        = 28;
  localparam int DCF_HOUR_LSB  = 29;
  localparam int DCF_P2        = 35;
  localparam int DCF_DAY_LSB   = 36;
  localparam int DCF_WDAY_LSB  = 42;
  localparam int DCF_MON_LSB   = 45;
  localparam int DCF_YEAR_LSB  = 50;
  localparam int DCF_P3        = 58;
  typedef enum logic {IDLE, SEND} dcf_state_t;
  typedef struct packed {
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] weekday;
    logic [4:0] month;
    logic [7:0] year;
    logic [4:0] flags;
  } dcf_time_t;
endpackage

// File: rtl/dcf77_transmitter_if.sv
// dcf77_transmitter_if: time load, pacing enable and pulse-train outputs of the transmitter
interface dcf77_transmitter_if;
  logic       clk_en;
  logic       load;
  logic [6:0] minute;
  logic [5:0] hour;
  logic [5:0] day;
  logic [2:0] weekday;
  logic [4:0] month;
  logic [7:0] year;
  logic [4:0] flags;
  logic       dcf_out;
  logic       sec_strobe;
  logic       minute_mark;
  logic       busy;
  logic       underrun;
  modport master (
    output clk_en, load, minute, hour, day, weekday, month, year, flags,
    input  dcf_out, sec_strobe, minute_mark, busy, underrun
  );
  modport slave (
    input  clk_en, load, minute, hour, day, weekday, month, year, flags,
    output dcf_out, sec_strobe, minute_mark, busy, underrun
  );
endinterface

// File: rtl/dcf77_frame_encoder.sv
// dcf77_frame_encoder: builds the 59-bit minute frame with even parities from a BCD time
module dcf77_frame_encoder
  import dcf77_pkg::*;
(
  input  dcf_time_t            i_time,
  output logic [DCF_LEN-1:0]   o_frame
);
  always_comb begin
    o_frame = '0;
    // R lands on bit 15, A2 on bit 19
    o_frame[DCF_FLAGS_LSB +: 5] = {i_time.flags[0], i_time.flags[1], i_time.flags[2],
                                   i_time.flags[3], i_time.flags[4]};
    o_frame[DCF_START] = 1'b1;
    o_frame[DCF_MIN_LSB +: 7] = i_time.minute;
    o_frame[DCF_P1] = ^i_time.minute;
    o_frame[DCF_HOUR_LSB +: 6] = i_time.hour;
    o_frame[DCF_P2] = ^i_time.hour;
    o_frame[DCF_DAY_LSB +: 6] = i_time.day;
    o_frame[DCF_WDAY_LSB +: 3] = i_time.weekday;
    o_frame[DCF_MON_LSB +: 5] = i_time.month;
    o_frame[DCF_YEAR_LSB +: 8] = i_time.year;
    o_frame[DCF_P3] = ^{i_time.day, i_time.weekday, i_time.month, i_time.year};
  end
endmodule

// File: rtl/dcf77_transmitter.sv
// dcf77_transmitter: double-buffered DCF77 pulse-train generator paced by a 10 ms enable
module dcf77_transmitter
  import dcf77_pkg::*;
#(
  parameter logic [6:0] TICKS_PER_SEC = 7'd100,
  parameter logic [6:0] TICKS_ZERO    = 7'd10,
  parameter logic [6:0] TICKS_ONE     = 7'd20
) (
  input logic clk,
  input logic rst_n,
  dcf77_transmitter_if.slave bus
);
  dcf_state_t         r_state, w_state;
  dcf_time_t          r_pend;
  logic               r_pend_vld;
  logic [DCF_LEN:0]   r_active;
  logic [6:0]         r_tick, w_tick;
  logic [5:0]         r_sec, w_sec;
  logic               r_dcf, r_ss, r_mm, r_under;
  logic               w_dcf, w_ss, w_mm, w_start, w_under, w_wrap;
  logic [DCF_LEN-1:0] w_frame;

  dcf77_frame_encoder u_enc (.i_time(r_pend), .o_frame(w_frame));

  assign w_wrap = r_tick == TICKS_PER_SEC - 7'd1;

  always_comb begin
    w_state = r_state;
    w_tick = r_tick;
    w_sec = r_sec;
    w_dcf = r_dcf;
    w_ss = 1'b0;
    w_mm = 1'b0;
    w_start = 1'b0;
    w_under = 1'b0;
    if (bus.clk_en) begin
      if (r_state == IDLE) w_start = r_pend_vld;
      else if (w_wrap && r_sec == 6'd59) begin
        w_start = r_pend_vld;
        w_under = !r_pend_vld;
        w_state = r_pend_vld ? SEND : IDLE;
        w_dcf = 1'b0;
      end else begin
        w_tick = w_wrap ? 7'd0 : r_tick + 7'd1;
        w_sec = w_wrap ? r_sec + 6'd1 : r_sec;
        w_ss = w_wrap;
        // r_active[59] is a constant 0 pad so second 59 indexes safely
        w_dcf = w_sec != 6'd59 && w_tick < (r_active[w_sec] ? TICKS_ONE : TICKS_ZERO);
      end
      if (w_start) begin
        w_state = SEND;
        w_tick = '0;
        w_sec = '0;
        w_ss = 1'b1;
        w_mm = 1'b1;
        w_dcf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tick <= '0;
      r_sec <= '0;
      r_dcf <= 1'b0;
      r_ss <= 1'b0;
      r_mm <= 1'b0;
      r_under <= 1'b0;
      r_pend <= '0;
      r_pend_vld <= 1'b0;
      r_active <= '0;
    end else begin
      r_state <= w_state;
      r_tick <= w_tick;
      r_sec <= w_sec;
      r_dcf <= w_dcf;
      r_ss <= w_ss;
      r_mm <= w_mm;
      if (w_start) r_active <= {1'b0, w_frame};
      // a load in the wrap clock becomes the next pending frame after the old one is consumed
      if (bus.load) r_pend <= {bus.minute, bus.hour, bus.day, bus.weekday, bus.month, bus.year, bus.flags};
      r_pend_vld <= bus.load || (r_pend_vld && !w_start);
      r_under <= bus.load ? 1'b0 : (r_under || w_under);
    end
  end

  assign bus.dcf_out = r_dcf;
  assign bus.sec_strobe = r_ss;
  assign bus.minute_mark = r_mm;
  assign bus.busy = r_state == SEND;
  assign bus.underrun = r_under;
endmodule

// File: tb/tb_dcf77_transmitter.sv
// tb_dcf77_transmitter: scoreboard of expected frames checked second by second against the pulse train
module tb_dcf77_transmitter;
  logic clk;
  logic rst_n;
  dcf77_transmitter_if bus ();

  dcf77_transmitter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [59:0] sb[$];
  logic [59:0] exp_f = '0;
  bit m_act = 0;
  int m_sec = 0;
  int m_tick = 0;
  int m_cnt = 0;
  int n_mm = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [59:0] enc(input logic [6:0] mi, input logic [5:0] h, input logic [5:0] d,
                                      input logic [2:0] wd, input logic [4:0] mo, input logic [7:0] y,
                                      input logic [4:0] fl);
    logic [59:0] f = '0;
    f[15] = fl[4];
    f[16] = fl[3];
    f[17] = fl[2];
    f[18] = fl[1];
    f[19] = fl[0];
    f[20] = 1'b1;
    f[27:21] = mi;
    f[28] = ^mi;
    f[34:29] = h;
    f[35] = ^h;
    f[41:36] = d;
    f[44:42] = wd;
    f[49:45] = mo;
    f[57:50] = y;
    f[58] = ^{d, wd, mo, y};
    return f;
  endfunction

  task automatic end_sec(input int len);
    chk($sformatf("s%0d_len", m_sec), len, 100);
    chk($sformatf("s%0d_pulse", m_sec), m_cnt, m_sec == 59 ? 0 : (exp_f[m_sec] ? 20 : 10));
  endtask

  task automatic bail(input string tag);
    chk(tag, 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  endtask

  task automatic wait_at(input int s, input int t);
    int k = 0;
    do begin
      @(posedge clk); #2;
      k++;
    end while (!(m_act && m_sec == s && m_tick == t) && k < 20000);
    if (k >= 20000) bail($sformatf("timeout_s%0d_t%0d", s, t));
  endtask

  task automatic wait_mm(input int n);
    int k = 0;
    while (n_mm < n && k < 20000) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 20000) bail($sformatf("timeout_mm%0d", n));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 20000) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 20000) bail("timeout_idle");
  endtask

  task automatic do_load(input logic [6:0] mi, input logic [5:0] h, input logic [5:0] d,
                         input logic [2:0] wd, input logic [4:0] mo, input logic [7:0] y,
                         input logic [4:0] fl, input bit with_en);
    @(negedge clk); #1;
    while (with_en && !bus.clk_en) begin
      @(negedge clk); #1;
    end
    bus.minute = mi;
    bus.hour = h;
    bus.day = d;
    bus.weekday = wd;
    bus.month = mo;
    bus.year = y;
    bus.flags = fl;
    bus.load = 1'b1;
    sb.push_back(enc(mi, h, d, wd, mo, y, fl));
    @(negedge clk); #1;
    bus.load = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.clk_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.clk_en = ~bus.clk_en;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) m_act = 0;
    else if (!bus.clk_en) chk("strobe_no_en", {bus.sec_strobe, bus.minute_mark}, 0);
    else begin
      if (bus.sec_strobe) begin
        if (m_act) end_sec(m_tick + 1);
        if (bus.minute_mark) begin
          n_mm++;
          chk("mm_sb", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_f = sb.pop_front();
            m_act = 1;
          end
          m_sec = 0;
        end else m_sec++;
        m_tick = 0;
        m_cnt = 0;
      end else begin
        chk("mm_no_ss", bus.minute_mark, 0);
        m_tick++;
      end
      if (bus.dcf_out) m_cnt++;
      if (!bus.busy) chk("idle_dcf", bus.dcf_out, 0);
      if (m_act && !bus.busy) begin
        end_sec(m_tick);
        m_act = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.minute = '0;
    bus.hour = '0;
    bus.day = '0;
    bus.weekday = '0;
    bus.month = '0;
    bus.year = '0;
    bus.flags = '0;
    repeat (6) @(posedge clk);
    #2;
    chk("rst_dcf", bus.dcf_out, 0);
    chk("rst_ss", bus.sec_strobe, 0);
    chk("rst_mm", bus.minute_mark, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ur", bus.underrun, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("idle_busy", bus.busy, 0);
    do_load(7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 5'b00000, 1'b0);
    wait_mm(1);
    chk("f1_busy", bus.busy, 1);
    wait_at(30, 0);
    do_load(7'h35, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 5'b00000, 1'b0);
    wait_mm(2);
    chk("wrap_busy", bus.busy, 1);
    wait_idle();
    chk("ur_set", bus.underrun, 1);
    chk("ur_dcf", bus.dcf_out, 0);
    chk("ur_busy", bus.busy, 0);
    chk("mm_count", n_mm, 2);
    do_load(7'h07, 6'h23, 6'h31, 3'd7, 5'h12, 8'h99, 5'b10001, 1'b0);
    chk("ur_clr", bus.underrun, 0);
    wait_mm(3);
    wait_at(10, 0);
    do_load(7'h59, 6'h00, 6'h01, 3'd1, 5'h01, 8'h00, 5'b00000, 1'b0);
    wait_at(59, 99);
    do_load(7'h42, 6'h19, 6'h28, 3'd5, 5'h11, 8'h57, 5'b01110, 1'b1);
    wait_mm(4);
    chk("f4_busy", bus.busy, 1);
    wait_mm(5);
    wait_at(20, 5);
    chk("pre_rst_dcf", bus.dcf_out, 1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_dcf", bus.dcf_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_busy", bus.busy, 0);
    do_load(7'h00, 6'h00, 6'h01, 3'd2, 5'h01, 8'h25, 5'b00000, 1'b0);
    wait_mm(6);
    wait_at(2, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
